dm_cache_ctrl: RTL and testbench



---
 rtl/dm_cache_ctrl.sv | 157 +++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped cache sequencing controller: tag/valid lookup, block refill, word return.
// Optional hit/miss counters are built when DM_CACHE_CTRL_STATS_EN is defined.
module dm_cache_ctrl #(
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 4,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_addr,
    output logic                resp_valid,
    output logic                resp_hit,
    output logic [DATA_W-1:0]   resp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [31:0]         mem_req_addr,
    input  logic                mem_rd_valid,
    input  logic [DATA_W-1:0]   mem_rd_data,
    output logic [INDEX_W-1:0]  arr_index,
    output logic [OFFSET_W-1:0] arr_offset,
    output logic                arr_we,
    output logic [DATA_W-1:0]   arr_wdata,
    input  logic [DATA_W-1:0]   arr_rdata
`ifdef DM_CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
`endif
);

    localparam int TAG_W = 32 - INDEX_W - OFFSET_W - 2;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, RESP} state_t;

    state_t              state;
    logic [TAG_W-1:0]    tags [LINES];
    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    a_tag;
    logic [INDEX_W-1:0]  a_idx;
    logic [OFFSET_W-1:0] a_off;
    logic [OFFSET_W-1:0] beat;
    logic                hit;
    logic                last_beat;
    logic                unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[1:0];
    assign hit       = valid[a_idx] && (tags[a_idx] == a_tag);
    assign last_beat = (beat == {OFFSET_W{1'b1}});

    // In IDLE the array address follows the incoming request so the read
    // data is already available when the lookup runs one cycle later.
    always_comb begin
        req_ready  = (state == IDLE) && !rst;
        arr_index  = a_idx;
        arr_offset = a_off;
        arr_we     = 1'b0;
        arr_wdata  = '0;
        case (state)
            IDLE: begin
                arr_index  = req_addr[OFFSET_W+2 +: INDEX_W];
                arr_offset = req_addr[2 +: OFFSET_W];
            end
            REFILL: begin
                arr_offset = beat;
                if (mem_rd_valid && !rst) begin
                    arr_we    = 1'b1;
                    arr_wdata = mem_rd_data;
                end
            end
            default: ;
        endcase
    end

    // Tags carry no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (!rst && state == REFILL && mem_rd_valid && last_beat)
            tags[a_idx] <= a_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            valid         <= '0;
            beat          <= '0;
            a_tag         <= '0;
            a_idx         <= '0;
            a_off         <= '0;
            resp_valid    <= 1'b0;
            resp_hit      <= 1'b0;
            resp_data     <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
`ifdef DM_CACHE_CTRL_STATS_EN
            hit_count     <= '0;
            miss_count    <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_tag <= req_addr[31 -: TAG_W];
                        a_idx <= req_addr[OFFSET_W+2 +: INDEX_W];
                        a_off <= req_addr[2 +: OFFSET_W];
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        resp_data  <= arr_rdata;
                        resp_hit   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= RESP;
`ifdef DM_CACHE_CTRL_STATS_EN
                        hit_count  <= hit_count + 32'd1;
`endif
                    end else begin
                        // Invalidate now so a refill cut short by reset never looks valid.
                        valid[a_idx]  <= 1'b0;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= {a_tag, a_idx, {(OFFSET_W+2){1'b0}}};
                        state         <= MISS_REQ;
`ifdef DM_CACHE_CTRL_STATS_EN
                        miss_count    <= miss_count + 32'd1;
`endif
                    end
                end
                MISS_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        beat          <= '0;
                        state         <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_rd_valid) begin
                        beat <= beat + 1'b1;
                        if (beat == a_off)
                            resp_data <= mem_rd_data;
                        if (last_beat) begin
                            valid[a_idx] <= 1'b1;
                            resp_hit     <= 1'b0;
                            resp_valid   <= 1'b1;
                            state        <= RESP;
                        end
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: memory/array models plus a response scoreboard.
// Stats counters are checked when DM_CACHE_CTRL_STATS_EN is defined.
module tb_dm_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        resp_valid;
    logic        resp_hit;
    logic [31:0] resp_data;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rd_valid = 1'b0;
    logic [31:0] mem_rd_data = '0;
    logic [7:0]  arr_index;
    logic [3:0]  arr_offset;
    logic        arr_we;
    logic [31:0] arr_wdata;
    logic [31:0] arr_rdata;
`ifdef DM_CACHE_CTRL_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [32:0] q[$];
    logic [32:0] mon_e;
    logic [31:0] amem [4096];

    always #5 clk = ~clk;

    dm_cache_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_data(resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .arr_index(arr_index), .arr_offset(arr_offset), .arr_we(arr_we),
        .arr_wdata(arr_wdata), .arr_rdata(arr_rdata)
`ifdef DM_CACHE_CTRL_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    // External data array: synchronous read, one-cycle latency
    always @(posedge clk) begin
        if (arr_we) amem[{arr_index, arr_offset}] <= arr_wdata;
        arr_rdata <= amem[{arr_index, arr_offset}];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (q.size() == 0) begin
                chk("resp_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = q.pop_front();
                chk("resp_hit", {63'd0, resp_hit}, {63'd0, mon_e[32]});
                chk("resp_data", {32'd0, resp_data}, {32'd0, mon_e[31:0]});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
    endtask

    task automatic hit_read(input logic [31:0] addr, input logic [31:0] data);
        wait_ready();
        req_valid = 1'b1;
        req_addr  = addr;
        q.push_back({1'b1, data});
        @(negedge clk);
        req_valid = 1'b0;
        chk("lookup_arr_we", {63'd0, arr_we}, 64'd0);
        @(negedge clk);
        chk("hit_resp_valid", {63'd0, resp_valid}, 64'd1);
        chk("hit_no_mem_req", {63'd0, mem_req_valid}, 64'd0);
    endtask

    task automatic miss_read(input logic [31:0] addr, input int stall,
                             input logic [31:0] base, input int nbeats);
        logic [31:0] maddr;
        logic [7:0]  idx;
        logic [3:0]  off;
        maddr = {addr[31:6], 6'b0};
        idx   = addr[13:6];
        off   = addr[5:2];
        wait_ready();
        req_valid = 1'b1;
        req_addr  = addr;
        if (nbeats == 16) q.push_back({1'b0, base + {28'd0, off}});
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mem_req_valid", {63'd0, mem_req_valid}, 64'd1);
        chk("mem_req_addr", {32'd0, mem_req_addr}, {32'd0, maddr});
        for (int s = 0; s < stall; s++) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = 32'hDEAD_0000 + s;
            #1 chk("stall_stray_we", {63'd0, arr_we}, 64'd0);
            @(negedge clk);
            chk("stall_req_valid", {63'd0, mem_req_valid}, 64'd1);
            chk("stall_req_addr", {32'd0, mem_req_addr}, {32'd0, maddr});
        end
        mem_rd_valid  = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = base + b;
            #1;
            chk("beat_we", {63'd0, arr_we}, 64'd1);
            chk("beat_index", {56'd0, arr_index}, {56'd0, idx});
            chk("beat_offset", {60'd0, arr_offset}, b);
            chk("beat_wdata", {32'd0, arr_wdata}, {32'd0, base + b});
            @(negedge clk);
        end
        mem_rd_valid = 1'b0;
        if (nbeats == 16) chk("miss_resp_valid", {63'd0, resp_valid}, 64'd1);
    endtask

    initial begin
        logic seen;
        for (int i = 0; i < 4096; i++) amem[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_hit", {63'd0, resp_hit}, 64'd0);
        chk("rst_resp_data", {32'd0, resp_data}, 64'd0);
        chk("rst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_mem_req_addr", {32'd0, mem_req_addr}, 64'd0);
        chk("rst_arr_we", {63'd0, arr_we}, 64'd0);
        chk("rst_arr_wdata", {32'd0, arr_wdata}, 64'd0);
        rst = 1'b0;
        #1 chk("post_rst_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);

        miss_read(32'h0000_0044, 0, 32'hA0, 16);  // cold miss -> 0xA1
        hit_read(32'h0000_0078, 32'hAE);           // same line, offset 14
        miss_read(32'h0000_4044, 5, 32'hB0, 16);  // conflict with stall
        miss_read(32'h0000_0044, 0, 32'hC0, 16);  // evicted line misses again
`ifdef DM_CACHE_CTRL_STATS_EN
        chk("hit_count", {32'd0, hit_count}, 64'd1);
        chk("miss_count", {32'd0, miss_count}, 64'd3);
`endif
        hit_read(32'h0000_0044, 32'hC1);

        // Reset after beat 7 abandons the refill without a response
        miss_read(32'h0000_1288, 0, 32'hD0, 8);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_req_ready", {63'd0, req_ready}, 64'd0);
        rst = 1'b0;
        #1 chk("midrst_post_ready", {63'd0, req_ready}, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        chk("midrst_no_resp", {63'd0, seen}, 64'd0);
        miss_read(32'h0000_1288, 0, 32'hE0, 16);  // offset 2 -> 0xE2
        miss_read(32'h0000_0044, 0, 32'hF0, 16);  // all lines invalid after reset

        repeat (4) @(negedge clk);
        chk("queue_empty", q.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
